// File: rtl/cover_toggle_sink.sv
// cover_toggle_sink: sticky toggle-coverage bitmap with distinct-point counter, read port and sweep clear
module cover_toggle_sink #(
    parameter int COVER_TOTAL = 8940,
    parameter int ADDR_W = 8,
    parameter int CNT_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_word,
    input  logic [63:0]       in_bits,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [63:0]       rd_resp_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [CNT_W-1:0]  covered_count,
    output logic              err_range
);
    localparam int WORDS = (COVER_TOTAL + 63) / 64;
    localparam int LAST_BITS = COVER_TOTAL - (WORDS - 1) * 64;
    localparam logic [63:0] LAST_MASK = LAST_BITS == 64 ? '1 : (64'd1 << LAST_BITS) - 64'd1;
    localparam logic [ADDR_W:0] WORDS_L = WORDS[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_L = WORDS_L - 1'b1;
    localparam logic [ADDR_W-1:0] LAST_WORD = LAST_L[ADDR_W-1:0];

    typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;
    state_t state, state_nxt;

    logic [63:0] bitmap [WORDS];
    logic p_valid;
    logic [ADDR_W-1:0] p_word;
    logic [63:0] p_bits;
    logic [ADDR_W-1:0] sweep_k;
    logic alive, hit, rd, hit_ok, rd_ok;
    logic [63:0] new_bits;

    assign clr_busy = state != IDLE;
    assign in_ready = reset && alive && !clr_busy;
    assign rd_req_ready = !clr_busy && (!rd_resp_valid || rd_resp_ready);
    assign hit = in_valid && in_ready;
    assign rd = rd_req_valid && rd_req_ready;
    assign hit_ok = {1'b0, in_word} < WORDS_L;
    assign rd_ok = {1'b0, rd_req_addr} < WORDS_L;
    assign new_bits = p_bits & ~bitmap[p_word];

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (clr_start ? DRAIN : IDLE) :
                    state == DRAIN ? SWEEP :
                    ({1'b0, sweep_k} == LAST_L ? IDLE : SWEEP);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            alive <= 1'b0;
            p_valid <= 1'b0;
            p_word <= '0;
            p_bits <= '0;
            sweep_k <= '0;
            covered_count <= '0;
            err_range <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_data <= '0;
            for (int i = 0; i < WORDS; i++) bitmap[i] <= '0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
            p_valid <= hit && hit_ok;
            if (hit && hit_ok) begin
                p_word <= in_word;
                p_bits <= in_bits & (in_word == LAST_WORD ? LAST_MASK : '1);
            end
            if (p_valid) begin
                bitmap[p_word] <= bitmap[p_word] | p_bits;
                covered_count <= covered_count + CNT_W'($countones(new_bits));
            end
            if ((hit && !hit_ok) || (rd && !rd_ok)) err_range <= 1'b1;
            if (rd) begin
                rd_resp_valid <= 1'b1;
                rd_resp_data <= rd_ok ? bitmap[rd_req_addr] | (p_valid && p_word == rd_req_addr ? p_bits : '0) : '0;
            end else if (rd_resp_ready) begin
                rd_resp_valid <= 1'b0;
            end
            // sweep runs after DRAIN so it always wins over the final commit
            sweep_k <= state == SWEEP ? sweep_k + 1'b1 : '0;
            if (state == SWEEP) bitmap[sweep_k] <= '0;
            if (state == DRAIN) begin
                covered_count <= '0;
                err_range <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cover_toggle_sink.sv
// tb_cover_toggle_sink: table-driven hits plus read scoreboard and clear/reset corner sequences
module tb_cover_toggle_sink;
    logic        clock = 0;
    logic        reset = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [7:0]  in_word = '0;
    logic [63:0] in_bits = '0;
    logic        rd_req_valid = 0;
    logic        rd_req_ready;
    logic [7:0]  rd_req_addr = '0;
    logic        rd_resp_valid;
    logic        rd_resp_ready = 1;
    logic [63:0] rd_resp_data;
    logic        clr_start = 0;
    logic        clr_busy;
    logic [13:0] covered_count;
    logic        err_range;

    int ncmp = 0;
    int nbad = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [7:0]  word;
        logic [63:0] bits;
        logic [13:0] cnt;
        logic        err;
        logic [63:0] rdv;
    } vec_t;
    vec_t tv[10];

    cover_toggle_sink dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_bits(in_bits),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .covered_count(covered_count), .err_range(err_range)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // responses are scored on the falling edge before the edge that transfers them
    task automatic tick();
        @(negedge clock);
        if (reset && rd_resp_valid && rd_resp_ready) begin
            if (exp_q.size() == 0) check("rd_resp_unexpected", 64'd1, 64'd0);
            else check("rd_resp", rd_resp_data, exp_q.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic hit(input logic [7:0] w, input logic [63:0] b);
        in_valid = 1;
        in_word = w;
        in_bits = b;
        tick();
        in_valid = 0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [63:0] e);
        rd_req_valid = 1;
        rd_req_addr = a;
        exp_q.push_back(e);
        tick();
        rd_req_valid = 0;
    endtask

    initial begin
        int n;
        logic bad;
        tv[0] = '{8'd3,   64'h5,                 14'd2,   1'b0, 64'h5};
        tv[1] = '{8'd3,   64'h6,                 14'd3,   1'b0, 64'h7};
        tv[2] = '{8'd139, 64'hFFFFFFFFFFFFFFFF,  14'd47,  1'b0, 64'h00000FFFFFFFFFFF};
        tv[3] = '{8'd200, 64'hFFFF,              14'd47,  1'b1, 64'h0};
        tv[4] = '{8'd0,   64'h8000000000000001,  14'd49,  1'b1, 64'h8000000000000001};
        tv[5] = '{8'd3,   64'h7,                 14'd49,  1'b1, 64'h7};
        tv[6] = '{8'd138, 64'hF0,                14'd53,  1'b1, 64'hF0};
        tv[7] = '{8'd139, 64'h1,                 14'd53,  1'b1, 64'h00000FFFFFFFFFFF};
        tv[8] = '{8'd255, 64'hFFFFFFFFFFFFFFFF,  14'd53,  1'b1, 64'h0};
        tv[9] = '{8'd64,  64'hFFFFFFFFFFFFFFFF,  14'd117, 1'b1, 64'hFFFFFFFFFFFFFFFF};

        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_count", covered_count, 0);
        check("rst_err", err_range, 0);
        check("rst_resp_valid", rd_resp_valid, 0);
        check("rst_resp_data", rd_resp_data, 0);
        reset = 1;
        tick();
        check("in_ready_after_reset", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            hit(tv[i].word, tv[i].bits);
            tick();
            check("vec_count", covered_count, tv[i].cnt);
            check("vec_err", err_range, tv[i].err);
            rd(tv[i].word, tv[i].rdv);
        end

        hit(8'd10, 64'h1);
        hit(8'd10, 64'h3);
        tick();
        check("b2b_count", covered_count, 119);
        rd(8'd10, 64'h3);

        in_valid = 1;
        in_word = 8'd11;
        in_bits = 64'hF0;
        rd_req_valid = 1;
        rd_req_addr = 8'd11;
        exp_q.push_back(64'h0);
        tick();
        in_valid = 0;
        rd_req_valid = 0;
        rd(8'd11, 64'hF0);
        check("same_cycle_count", covered_count, 123);

        hit(8'd7, 64'h9);
        rd(8'd7, 64'h9);
        tick();
        check("fwd_count", covered_count, 125);

        rd_resp_ready = 0;
        rd(8'd3, 64'h7);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", rd_resp_valid, 1);
            check("stall_data", rd_resp_data, 64'h7);
            check("stall_req_ready", rd_req_ready, 0);
            tick();
        end
        rd_resp_ready = 1;
        tick();

        rd_resp_ready = 0;
        rd(8'd64, 64'hFFFFFFFFFFFFFFFF);
        clr_start = 1;
        tick();
        clr_start = 0;
        n = 0;
        bad = 0;
        while (clr_busy && n < 300) begin
            if (in_ready !== 1'b0) bad = 1;
            if (n == 10) rd_resp_ready = 1;
            tick();
            n++;
        end
        check("clr_cycles", n, 141);
        check("clr_in_ready_low", bad, 0);
        check("clr_count", covered_count, 0);
        check("clr_err", err_range, 0);
        check("clr_in_ready_after", in_ready, 1);
        check("clr_resp_drained", exp_q.size(), 0);
        rd(8'd3, 64'h0);
        rd(8'd64, 64'h0);
        rd(8'd139, 64'h0);
        rd(8'd0, 64'h0);
        tick();
        check("clr_err_after_reads", err_range, 0);

        hit(8'd100, 64'hFF);
        tick();
        check("pre_sweep_count", covered_count, 8);
        clr_start = 1;
        tick();
        clr_start = 0;
        repeat (51) tick();
        check("mid_sweep_busy", clr_busy, 1);
        reset = 0;
        tick();
        check("sweep_rst_busy", clr_busy, 0);
        check("sweep_rst_in_ready", in_ready, 0);
        check("sweep_rst_count", covered_count, 0);
        reset = 1;
        tick();
        check("sweep_rst_ready_after", in_ready, 1);
        rd(8'd100, 64'h0);
        tick();
        check("sweep_rst_count_after", covered_count, 0);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
